uart_code_rx: RTL
=================

// Module: uart_code_rx
// PURPOSE
//  Receive-side counterpart of the barcode UART reporter. Deserialises 8N1 UART bytes from uart_rx
//  and parses ASCII frames "Code:DDDDDDDDDDDDD\r\n" (13 decimal digits). Emits 13 BCD digits with a
//  one-cycle valid strobe. Sits between the board UART pin and the LCD/display or loop-back checker.
// PARAMETERS
//  CLK_FRE    50      system clock in MHz
//  UART_RATE  115200  baud; BIT_CYC = CLK_FRE*1_000_000/UART_RATE (434 at defaults), HALF = BIT_CYC/2
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  rst         in   1        synchronous, active-high reset
//  uart_rx     in   1        async serial line, idle high
//  recv_data   out  8        last correctly framed byte
//  recv_en     out  1        1-cycle strobe, recv_data valid
//  code_data   out  [12:0][3:0]  BCD digits; code_data[0] = first digit after "Code:"
//  code_valid  out  1        1-cycle strobe, complete valid frame latched into code_data
//  code_err    out  1        1-cycle strobe, frame aborted (framing error, bad char, bad checksum)
// BEHAVIOUR
//  Reset: all outputs 0, code_data all 0, both FSMs idle, 2-flop synchroniser preset to 1.
//  Bit FSM (IDLE,START,DATA,STOP): IDLE->START on synchronised 1->0; at HALF cycles re-sample: high
//   -> IDLE (glitch, no strobe); low -> DATA. Sample 8 bits LSB first every BIT_CYC at mid-bit.
//   STOP sample 1 -> recv_en=1, recv_data updated same cycle. STOP sample 0 -> framing error: no
//   recv_en, parser forced to HUNT, code_err=1 if parser was past HUNT index 0. Back to IDLE
//   immediately after stop mid-sample (next start edge accepted at once).
//  Parser FSM (HUNT,DIGIT,CR,LF), acts only on recv_en cycles:
//   HUNT: idx 0..4 matches "Code:"; mismatch -> idx=1 if byte=="C" else 0, no error. idx 4 match
//    -> DIGIT, dcnt=0.
//   DIGIT: byte in 0x30..0x39 -> shadow[dcnt]=byte-0x30, dcnt++; after 13th -> CR. Other byte ->
//    code_err, HUNT (idx 0, or 1 if "C").
//   CR: 0x0D -> LF, else code_err, HUNT. LF: 0x0A -> copy shadow to code_data, code_valid=1 on the
//    cycle after LF recv_en, HUNT; else code_err, HUNT.
//  Latency: code_valid 1 clk after LF stop-bit sample. code_data stable between frames; never
//   partially updated. code_valid and code_err never both high.
//  Reset mid-byte or mid-frame: all partial state discarded, no strobes.
//  Back-to-back frames with no idle gap: supported.
// CONFIGURATION
//  UART_CODE_CHECKSUM_EN defined: EAN-13 check. Running sum s (8b) += d*(dcnt odd?3:1) for digits
//   0..11; at LF require digit12 == (10 - s%10)%10, else code_err instead of code_valid, code_data kept.
//  Undefined: any 13 digits accepted; checksum logic absent.
// STRUCTURE
//  Shared package uart_pkg: bit-FSM enum, parser enum, PREFIX="Code:", DIGIT_NUM=13, CR/LF consts.
//  Sub-module uart_rx (synchroniser + bit FSM, ports clk,rst,rx_pin,recv_data,recv_en,frame_err);
//  parser + checksum in this module.
// TESTING
//  1 "Code:4006381333931\r\n" at 115200 -> one code_valid, code_data = 4,0,0,6,3,8,1,3,3,3,9,3,1.
//  2 "Code:4006381333932\r\n" -> CHECKSUM_EN: code_err, code_data unchanged; off: code_valid.
//  3 "CCode:" + valid digits + CRLF -> code_valid (prefix restart on "C").
//  4 "Code:40063A..." -> code_err on 'A' recv_en+1, no code_valid; next valid frame accepted.
//  5 byte with stop bit driven 0 mid-digits -> no recv_en, code_err, parser in HUNT.
//  6 400 ns low glitch on idle line -> no recv_en; rst pulse during digit 7 -> no strobes, next frame ok.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the barcode UART receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: bit-FSM and parser state enums, frame prefix/terminator characters,
// BCD code vector type, prefix lookup and EAN-13 check-digit helpers.
package uart_pkg;

    localparam int DIGIT_NUM  = 13;
    localparam int PREFIX_LEN = 5;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_C  = 8'h43;

    // Packed so that PREFIX[4] is 'C' and PREFIX[0] is ':'.
    localparam logic [PREFIX_LEN-1:0][7:0] PREFIX = "Code:";

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_t;

    typedef enum logic [1:0] {
        P_HUNT,
        P_DIGIT,
        P_CR,
        P_LF
    } parse_state_t;

    typedef logic [DIGIT_NUM-1:0][3:0] bcd_t;

    // Character expected at prefix position idx (0 = 'C').
    function automatic logic [7:0] prefix_char(input logic [2:0] idx);
        return PREFIX[3'(PREFIX_LEN - 1) - idx];
    endfunction

    // EAN-13 check digit from the weighted sum of the first twelve digits.
    function automatic logic [3:0] ean_check(input logic [7:0] sum);
        logic [3:0] r;
        r = 4'(sum % 8'd10);
        return (r == 4'd0) ? 4'd0 : 4'(4'd10 - r);
    endfunction

endpackage

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART byte receiver: 2-flop synchroniser, start-bit glitch filter, mid-bit sampling.
// Latency: recv_en/frame_err rise one clk after the stop-bit mid-sample.
// Backpressure: none; strobes are one cycle and must be consumed when presented.
// Ports: clk, rst (sync, active high), rx_pin (async line, idle high),
//        recv_data (last good byte), recv_en (good-byte strobe), frame_err (stop bit low strobe).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] recv_data,
    output logic       recv_en,
    output logic       frame_err
);

    localparam int BIT_CYC = CLK_FRE * 1_000_000 / UART_RATE;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CW      = $clog2(BIT_CYC);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    bit_state_t       state;
    bit_state_t       state_nxt;
    logic [CW-1:0]    cyc_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             half_tick;
    logic             bit_tick;

    assign half_tick = (cyc_cnt == CW'(HALF - 1));
    assign bit_tick  = (cyc_cnt == CW'(BIT_CYC - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            BIT_IDLE:  if (rx_prev && !rx_sync) state_nxt = BIT_START;
            // A line that is high again at half a bit was a glitch, not a start bit.
            BIT_START: if (half_tick) state_nxt = rx_sync ? BIT_IDLE : BIT_DATA;
            BIT_DATA:  if (bit_tick && bit_idx == 3'd7) state_nxt = BIT_STOP;
            // Leave at the stop mid-sample so a back-to-back start edge is not missed.
            BIT_STOP:  if (bit_tick) state_nxt = BIT_IDLE;
            default:   state_nxt = BIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= BIT_IDLE;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            recv_data <= '0;
            recv_en   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx_pin;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            state     <= state_nxt;
            recv_en   <= 1'b0;
            frame_err <= 1'b0;

            if (state == BIT_IDLE || (state == BIT_START && half_tick) || bit_tick)
                cyc_cnt <= '0;
            else
                cyc_cnt <= cyc_cnt + 1'b1;

            if (state == BIT_START)
                bit_idx <= '0;

            if (state == BIT_DATA && bit_tick) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == BIT_STOP && bit_tick) begin
                if (rx_sync) begin
                    recv_en   <= 1'b1;
                    recv_data <= shift;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_code_rx.sv
`timescale 1ns/1ps
// Barcode frame receiver: parses "Code:" + 13 ASCII digits + CR LF from a UART line into BCD.
// Latency: code_valid/code_err one clk after the recv_en (or framing error) that decides the frame.
// Backpressure: none; all outputs are one-cycle strobes, code_data holds until the next good frame.
// Ports: clk, rst (sync, active high), uart_rx (line), recv_data/recv_en (raw bytes),
//        code_data (13 BCD digits, [0] first), code_valid, code_err.
// Option: define UART_CODE_CHECKSUM_EN to require a correct EAN-13 check digit.
module uart_code_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] recv_data,
    output logic       recv_en,
    output bcd_t       code_data,
    output logic       code_valid,
    output logic       code_err
);

    logic         frame_err;
    parse_state_t p_state;
    parse_state_t p_state_nxt;
    logic [2:0]   idx;
    logic [2:0]   idx_nxt;
    logic [3:0]   dcnt;
    logic [3:0]   dcnt_nxt;
    bcd_t         shadow;
    logic         shadow_we;
    logic         commit;
    logic         valid_nxt;
    logic         err_nxt;
    logic         is_digit;
    logic [2:0]   restart_idx;
    logic [3:0]   digit;
    logic         sum_ok;
`ifdef UART_CODE_CHECKSUM_EN
    logic [7:0]   sum;
`endif

    uart_rx #(
        .CLK_FRE   (CLK_FRE),
        .UART_RATE (UART_RATE)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_pin    (uart_rx),
        .recv_data (recv_data),
        .recv_en   (recv_en),
        .frame_err (frame_err)
    );

    assign is_digit    = (recv_data >= 8'h30) && (recv_data <= 8'h39);
    assign digit       = recv_data[3:0];
    // A stray 'C' may itself be the start of the next prefix.
    assign restart_idx = (recv_data == CHAR_C) ? 3'd1 : 3'd0;

`ifdef UART_CODE_CHECKSUM_EN
    assign sum_ok = (shadow[DIGIT_NUM-1] == ean_check(sum));
`else
    assign sum_ok = 1'b1;
`endif

    always_comb begin
        p_state_nxt = p_state;
        idx_nxt     = idx;
        dcnt_nxt    = dcnt;
        shadow_we   = 1'b0;
        commit      = 1'b0;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        if (frame_err) begin
            p_state_nxt = P_HUNT;
            idx_nxt     = 3'd0;
            err_nxt     = (p_state != P_HUNT) || (idx != 3'd0);
        end else if (recv_en) begin
            case (p_state)
                P_HUNT: begin
                    if (recv_data == prefix_char(idx)) begin
                        if (idx == 3'(PREFIX_LEN - 1)) begin
                            p_state_nxt = P_DIGIT;
                            idx_nxt     = 3'd0;
                            dcnt_nxt    = 4'd0;
                        end else begin
                            idx_nxt = idx + 3'd1;
                        end
                    end else begin
                        idx_nxt = restart_idx;
                    end
                end
                P_DIGIT: begin
                    if (is_digit) begin
                        shadow_we = 1'b1;
                        dcnt_nxt  = dcnt + 4'd1;
                        if (dcnt == 4'(DIGIT_NUM - 1))
                            p_state_nxt = P_CR;
                    end else begin
                        err_nxt     = 1'b1;
                        p_state_nxt = P_HUNT;
                        idx_nxt     = restart_idx;
                    end
                end
                P_CR: begin
                    if (recv_data == CHAR_CR) begin
                        p_state_nxt = P_LF;
                    end else begin
                        err_nxt     = 1'b1;
                        p_state_nxt = P_HUNT;
                        idx_nxt     = restart_idx;
                    end
                end
                P_LF: begin
                    p_state_nxt = P_HUNT;
                    if (recv_data == CHAR_LF && sum_ok) begin
                        commit    = 1'b1;
                        valid_nxt = 1'b1;
                        idx_nxt   = 3'd0;
                    end else begin
                        err_nxt = 1'b1;
                        idx_nxt = (recv_data == CHAR_LF) ? 3'd0 : restart_idx;
                    end
                end
                default: begin
                    p_state_nxt = P_HUNT;
                    idx_nxt     = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state    <= P_HUNT;
            idx        <= '0;
            dcnt       <= '0;
            shadow     <= '0;
            code_data  <= '0;
            code_valid <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            p_state    <= p_state_nxt;
            idx        <= idx_nxt;
            dcnt       <= dcnt_nxt;
            code_valid <= valid_nxt;
            code_err   <= err_nxt;
            if (shadow_we)
                shadow[dcnt] <= digit;
            // Whole-vector copy: code_data never shows a partially received frame.
            if (commit)
                code_data <= shadow;
        end
    end

`ifdef UART_CODE_CHECKSUM_EN
    // Digits 0..11 weighted 1,3,1,3...; max 216 so 8 bits never overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (recv_en && p_state == P_HUNT && idx == 3'(PREFIX_LEN - 1)) begin
            sum <= '0;
        end else if (shadow_we && dcnt < 4'(DIGIT_NUM - 1)) begin
            sum <= sum + ({4'd0, digit} * (dcnt[0] ? 8'd3 : 8'd1));
        end
    end
`endif

endmodule
